// File: rtl/serial_pkg.sv
// serial_pkg: shared UART receiver state encoding and default bit timing.
package serial_pkg;
    localparam logic [15:0] WTIME_DEFAULT = 16'h0364;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: two-stage synchronizer with a selectable reset value.
module sync_ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);
    logic [1:0] s;
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) s <= {2{RST_VAL}};
        else       s <= {s[0], d};
    assign q = s[1];
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a one-entry output buffer,
// frame-error and overrun pulses.
module uart_rx_core import serial_pkg::*; #(
    parameter logic [15:0] WTIME = WTIME_DEFAULT
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       uart_txd_in,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       o_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);
    localparam logic [15:0] HALF = WTIME >> 1;
    rx_state_t   state, state_nx;
    logic        rxd, rxd_q, tick, done, ferr;
    logic [15:0] cnt, lim;
    logic [2:0]  bits;
    logic [7:0]  shreg;
    sync_ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .nrst(nrst), .d(uart_txd_in), .q(rxd));
    // the start bit is sampled at half period, every later bit one full period on
    assign lim  = (state == START) ? HALF : WTIME;
    assign tick = (cnt == lim - 16'd1);
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        ferr     = 1'b0;
        case (state)
            IDLE:      state_nx = (rxd_q && !rxd) ? START : IDLE;
            START:     state_nx = !tick ? START : (rxd ? IDLE : DATA);
            DATA:      state_nx = (tick && bits == 3'd7) ? STOP : DATA;
            STOP: begin
                state_nx = !tick ? STOP : (rxd ? IDLE : WAIT_HIGH);
                done     = tick && rxd;
                ferr     = tick && !rxd;
            end
            WAIT_HIGH: state_nx = rxd ? IDLE : WAIT_HIGH;
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            rxd_q <= 1'b1;
            cnt   <= '0;
            bits  <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            rxd_q <= rxd;
            cnt   <= (state == IDLE || state == WAIT_HIGH || tick) ? 16'd0 : cnt + 16'd1;
            bits  <= (state == IDLE) ? 3'd0 : (state == DATA && tick) ? bits + 3'd1 : bits;
            shreg <= (state == DATA && tick) ? {rxd, shreg[7:1]} : shreg;
        end
    end
    // a byte completing in the same cycle the old one is taken replaces it
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= ferr;
            o_overrun   <= done && o_valid && !o_ready;
            if (done && (!o_valid || o_ready)) begin
                o_data  <= shreg;
                o_valid <= 1'b1;
            end else if (o_valid && o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule
